// File: rtl/inst_fetch_cache.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_cache
// Purpose  : Direct-mapped, read-only instruction cache that sits between the
//            core fetch port and a multi-cycle instruction memory. Hits return
//            in the same cycle. A miss stalls the core while the whole line is
//            refilled one beat at a time over a valid-strobe handshake.
// Ports    : clk         - clock, rising edge
//            rst_b       - synchronous reset, active-high
//            inst_addr   - fetch byte address (bits [1:0] ignored)
//            inst        - instruction word, 0 while stalled
//            stall       - 1 = instruction not available this cycle
//            flush       - invalidate every line
//            fill_req    - refill in progress, held for the whole refill
//            fill_addr   - line-aligned byte address being refilled
//            fill_data   - refill beat data
//            fill_valid  - refill beat strobe, one word per strobe
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_cache #(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst,
    output logic        stall,
    input  logic        flush,
    output logic        fill_req,
    output logic [31:0] fill_addr,
    input  logic [31:0] fill_data,
    input  logic        fill_valid
);

    localparam int c_W     = $clog2(WORDS);
    localparam int c_L     = $clog2(LINES);
    localparam int c_OFF   = 2 + c_W;           // byte offset width of a line
    localparam int c_TAG_W = 32 - c_OFF - c_L;

    localparam logic [c_W-1:0] c_LAST    = c_W'(WORDS - 1);
    localparam logic [c_W-1:0] c_CNT_ONE = c_W'(1);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_REFILL = 1'b1;

    // Storage
    logic [31:0]        r_data [LINES][WORDS];
    logic [c_TAG_W-1:0] r_tag  [LINES];
    logic [LINES-1:0]   r_valid;

    logic [0:0]         r_state;
    logic [c_W-1:0]     r_cnt;
    logic [31:0]        r_fill_addr;
    logic               r_discard;     // a flush landed during this refill

    // Lookup address split
    logic [c_W-1:0]     w_word;
    logic [c_L-1:0]     w_index;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_hit;

    // Refill target, taken from the latched line address
    logic [c_L-1:0]     w_fill_index;
    logic [c_TAG_W-1:0] w_fill_tag;
    logic               w_beat;

    logic               w_unused_addr_bits;

    assign w_word  = inst_addr[c_OFF-1:2];
    assign w_index = inst_addr[c_OFF+c_L-1:c_OFF];
    assign w_tag   = inst_addr[31:c_OFF+c_L];

    assign w_fill_index = r_fill_addr[c_OFF+c_L-1:c_OFF];
    assign w_fill_tag   = r_fill_addr[31:c_OFF+c_L];

    // Byte lane bits of the fetch address carry no information.
    assign w_unused_addr_bits = &{1'b0, inst_addr[1:0]};

    // Hits are suppressed while refilling so a partially written line, or a
    // lookup racing the refill, can never return stale data.
    assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag) &&
                   (r_state == c_IDLE) && !flush;

    assign stall     = !w_hit;
    assign inst      = w_hit ? r_data[w_index][w_word] : 32'h0;
    assign fill_req  = (r_state == c_REFILL);
    assign fill_addr = r_fill_addr;

    // A beat is only accepted while refilling and not in reset.
    assign w_beat = !rst_b && (r_state == c_REFILL) && fill_valid;

    // Data and tag arrays need no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_data[w_fill_index][r_cnt] <= fill_data;
            if (r_cnt == c_LAST) begin
                r_tag[w_fill_index] <= w_fill_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_valid     <= '0;
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_fill_addr <= '0;
            r_discard   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (!w_hit) begin
                        r_fill_addr      <= {inst_addr[31:c_OFF], {c_OFF{1'b0}}};
                        r_cnt            <= '0;
                        r_discard        <= 1'b0;
                        // Evict now so a partial line is never seen as valid.
                        r_valid[w_index] <= 1'b0;
                        r_state          <= c_REFILL;
                    end
                end
                c_REFILL: begin
                    if (flush) begin
                        r_valid   <= '0;
                        r_discard <= 1'b1;
                    end
                    if (fill_valid) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                        if (r_cnt == c_LAST) begin
                            // A flush at any point of the refill, including
                            // this last beat, leaves the line invalid.
                            if (!(flush || r_discard)) begin
                                r_valid[w_fill_index] <= 1'b1;
                            end
                            r_discard <= 1'b0;
                            r_state   <= c_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_cache
// Purpose  : Directed self-checking bench for inst_fetch_cache. Expected
//            instruction words come from a bench-side memory pattern, are
//            queued when a fetch is driven and popped when the DUT delivers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_cache;

    logic        clk        = 1'b0;
    logic        rst_b      = 1'b1;
    logic        flush      = 1'b0;
    logic        fill_valid = 1'b0;
    logic [31:0] inst_addr  = 32'h0;
    logic [31:0] fill_data  = 32'h0;
    logic [31:0] inst;
    logic        stall;
    logic        fill_req;
    logic [31:0] fill_addr;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    inst_fetch_cache #(
        .LINES (8),
        .WORDS (4)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .inst_addr  (inst_addr),
        .inst       (inst),
        .stall      (stall),
        .flush      (flush),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .fill_valid (fill_valid)
    );

    always #5 clk = ~clk;

    // Backing memory contents: word at byte address a (0x40 -> 0x1000).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return 32'h1000 + w - 32'd16;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", name, obs, exp);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, then settle.
    task automatic step(input logic [31:0] a, input logic fv, input logic [31:0] fd,
                        input logic fl, input logic rs);
        @(negedge clk);
        inst_addr  = a;
        fill_valid = fv;
        fill_data  = fd;
        flush      = fl;
        rst_b      = rs;
        #1;
    endtask

    task automatic expect_hit(input logic [31:0] a, input logic fv, input logic [31:0] fd,
                              input string tag);
        logic [31:0] e;
        exp_q.push_back(mem_word(a));
        step(a, fv, fd, 1'b0, 1'b0);
        e = exp_q.pop_front();
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        chk({tag, "_inst"}, inst, e);
    endtask

    // Miss on a, then feed beats per pat (bit i = strobe in cycle i).
    // flush_at selects a cycle of the pattern carrying flush (-1 = none).
    task automatic do_miss(input logic [31:0] a, input logic [15:0] pat, input int plen,
                           input int flush_at, input bit validate, input string tag);
        logic [31:0] line;
        logic [31:0] e;
        int          beat;
        int          stalls;
        line   = {a[31:4], 4'h0};
        beat   = 0;
        stalls = 0;
        step(a, 1'b0, 32'h0, 1'b0, 1'b0);
        chk({tag, "_miss_stall"}, {31'b0, stall}, 32'd1);
        chk({tag, "_miss_req"}, {31'b0, fill_req}, 32'd0);
        chk({tag, "_miss_inst"}, inst, 32'h0);
        if (stall === 1'b1) stalls++;
        for (int i = 0; i < plen; i++) begin
            step(a, pat[i], pat[i] ? mem_word(line + 32'(4 * beat)) : 32'hBAD0_0000,
                 (i == flush_at), 1'b0);
            chk({tag, "_req"}, {31'b0, fill_req}, 32'd1);
            chk({tag, "_fill_addr"}, fill_addr, line);
            chk({tag, "_fill_stall"}, {31'b0, stall}, 32'd1);
            if (stall === 1'b1) stalls++;
            if (pat[i]) beat++;
        end
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(1 + plen));
        if (validate) begin
            exp_q.push_back(mem_word(a));
            step(a, 1'b0, 32'h0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            chk({tag, "_done_req"}, {31'b0, fill_req}, 32'd0);
            chk({tag, "_hit_stall"}, {31'b0, stall}, 32'd0);
            chk({tag, "_hit_inst"}, inst, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst_b     = 1'b1;
        inst_addr = 32'h40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_fill_req", {31'b0, fill_req}, 32'd0);
        chk("reset_fill_addr", fill_addr, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'd1);
        chk("reset_inst", inst, 32'h0);

        // First refill, back-to-back beats, then sequential hits in the line
        do_miss(32'h40, 16'h000F, 4, -1, 1'b1, "line40");
        expect_hit(32'h44, 1'b0, 32'h0, "hit44");
        expect_hit(32'h48, 1'b0, 32'h0, "hit48");
        expect_hit(32'h4C, 1'b0, 32'h0, "hit4C");
        expect_hit(32'h4F, 1'b0, 32'h0, "hit4F");

        // Conflict on index 4: 0xC0 evicts 0x40, which then misses again
        do_miss(32'hC0, 16'h000F, 4, -1, 1'b1, "lineC0");
        do_miss(32'h40, 16'h000F, 4, -1, 1'b1, "line40_again");
        expect_hit(32'h48, 1'b0, 32'h0, "hit48_again");

        // Gappy refill 1,0,0,1,1,0,1 then check word ordering
        do_miss(32'h104, 16'h0059, 7, -1, 1'b1, "gappy");
        expect_hit(32'h100, 1'b0, 32'h0, "gappy_w0");
        expect_hit(32'h108, 1'b0, 32'h0, "gappy_w2");
        expect_hit(32'h10C, 1'b0, 32'h0, "gappy_w3");

        // Flush during the second beat: refill finishes but is not validated
        do_miss(32'h1A4, 16'h000F, 4, 1, 1'b0, "flush_refill");
        do_miss(32'h1A4, 16'h000F, 4, -1, 1'b1, "after_flush_same");
        do_miss(32'h40, 16'h000F, 4, -1, 1'b1, "after_flush_other");

        // Flush in IDLE: stalls that cycle and starts no refill
        expect_hit(32'h1A8, 1'b0, 32'h0, "pre_flush_hit");
        step(32'h1A8, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("idle_flush_stall", {31'b0, stall}, 32'd1);
        chk("idle_flush_inst", inst, 32'h0);
        do_miss(32'h1A8, 16'h000F, 4, -1, 1'b1, "after_idle_flush");

        // Reset during the second beat of a refill
        step(32'h2A0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("abort_miss", {31'b0, stall}, 32'd1);
        step(32'h2A0, 1'b1, mem_word(32'h2A0), 1'b0, 1'b0);
        chk("abort_beat1_req", {31'b0, fill_req}, 32'd1);
        step(32'h2A0, 1'b1, mem_word(32'h2A4), 1'b0, 1'b1);
        chk("abort_beat2_req", {31'b0, fill_req}, 32'd1);
        step(32'h2A0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("abort_req_dropped", {31'b0, fill_req}, 32'd0);
        chk("abort_stall", {31'b0, stall}, 32'd1);
        do_miss(32'h2A0, 16'h000F, 4, -1, 1'b1, "after_abort");

        // Stray beats while IDLE must not disturb a valid line
        expect_hit(32'h2A0, 1'b1, 32'hDEAD_0001, "stray0");
        expect_hit(32'h2A0, 1'b1, 32'hDEAD_0002, "stray1");
        expect_hit(32'h2A0, 1'b1, 32'hDEAD_0003, "stray2");
        expect_hit(32'h2A4, 1'b0, 32'h0, "stray_chk_w1");
        expect_hit(32'h2A8, 1'b0, 32'h0, "stray_chk_w2");
        expect_hit(32'h2AC, 1'b0, 32'h0, "stray_chk_w3");
        expect_hit(32'h2A0, 1'b0, 32'h0, "stray_chk_w0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_cache.md
Name: inst_fetch_cache

Overview:
- Direct-mapped, read-only instruction cache between the core's fetch port and a multi-cycle instruction memory.
- Core side: the core presents `inst_addr` and receives `inst` with a `stall` flag.
  - Hits return in the same cycle (zero added latency).
  - Misses stall the core while a full line is refilled over a valid-beat handshake.
- Software-visible `flush` invalidates all lines.

Parameters:
- LINES, 8, number of cache lines (power of 2, ≥2)
- WORDS, 4, 32-bit words per line (power of 2, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst_b  in  1  reset, synchronous, active-high
- inst_addr  in  32  byte address from the core PC; bits [1:0] ignored
- inst  out  32  instruction word; valid only when stall=0, else 32'h0
- stall  out  1  1 = instruction not available, core must hold PC
- flush  in  1  invalidate all lines
- fill_req  out  1  refill request, held high for the whole refill
- fill_addr  out  32  line-aligned byte address of the line being refilled
- fill_data  in  32  refill beat data
- fill_valid  in  1  refill beat strobe, one word per cycle when high

Behaviour:
- Address split, with W=log2(WORDS), L=log2(LINES):
  - word select = `inst_addr[2+W-1:2]`
  - index = `inst_addr[2+W+L-1:2+W]`
  - tag = `inst_addr[31:2+W+L]`
  - Defaults: word [3:2], index [6:4], tag [31:7].
- Storage:
  - data array LINES×WORDS×32
  - tag array LINES×tag-width
  - valid bit per line
- hit = valid[index] & (tag match) & state==IDLE & ~flush. All combinational from `inst_addr`.
- `stall` = ~hit. `inst` = data[index][word] when hit, else 0.
- Reset, effective on the clock edge where `rst_b`=1:
  - all valid bits cleared; state=IDLE; beat counter=0; `fill_req`=0; `fill_addr`=0
  - Consequently `stall`=1 in the first post-reset cycle.
- FSM states: IDLE, REFILL.
  - IDLE, miss and ~flush: latch `fill_addr` = {`inst_addr`[31:2+W], (2+W) zeros}, clear the beat counter, go to REFILL.
  - REFILL:
    - `fill_req`=1.
    - Each cycle with `fill_valid`=1 writes `fill_data` into data[latched index][counter] and increments the counter.
    - Beats arrive in order, word 0 first. Gaps (`fill_valid`=0) are allowed and do not advance the counter.
  - On the last beat (counter==WORDS-1 with `fill_valid`): write the tag, set valid (unless discarded, see flush rule), go to IDLE.
  - `fill_req` is 0 from the next cycle.
- Refill latency: the miss is detected in cycle 0, `fill_req` rises in cycle 1. The first possible hit is the cycle after the last beat.
  - Minimum miss penalty with back-to-back beats: WORDS+1 stall cycles (5 by default).
- Valid bit of the refilling line:
  - cleared on entry to REFILL, so a partial line is never hit;
  - the tag is written on the last beat.
- `inst_addr` changing during REFILL: the latched line refill completes regardless. The new address is looked up in IDLE afterwards, which may trigger another refill.
- `fill_valid` while in IDLE: ignored, no array writes.
- Flush rules:
  - IDLE: all valid bits clear at the edge. `stall`=1 in the flush cycle itself. No refill is started that cycle.
  - REFILL: all valid bits clear, and a discard flag is set. The refill continues to consume its remaining beats, but the line is not validated. Return to IDLE, discard flag cleared.
  - Flush on the last-beat cycle: line not validated.
- Reset mid-REFILL: abort immediately (state IDLE, `fill_req`=0 next cycle). Any further `fill_valid` beats are ignored.
- Aliasing: two addresses with the same index and different tags evict each other. There is no associativity.

Test Plan:
- Reset, `inst_addr`=0x0000_0040, memory returns 0x1000+i per beat back-to-back:
  - `fill_req` high for 4 cycles, `fill_addr`=0x40;
  - then `stall`=0, `inst`=0x1000;
  - total 5 stall cycles.
- After the line above, step `inst_addr` 0x44, 0x48, 0x4C (bits [1:0]=2'b11 on 0x4F as well):
  - zero stall, `inst`=0x1001, 0x1002, 0x1003, 0x1003.
- Conflict: load 0x40, then access 0xC0 (same index 4, tag 1):
  - miss and refill at `fill_addr`=0xC0;
  - afterwards 0x40 misses again.
- Gappy refill: `fill_valid` pattern 1,0,0,1,1,0,1:
  - line valid only after the 4th beat;
  - `stall`=1 throughout;
  - data words placed in order.
- Flush during the 2nd refill beat:
  - refill completes (`fill_req` drops after beat 4);
  - the same address then misses again;
  - a previously valid line at another index also misses.
- `rst_b` pulsed high during beat 2 of a refill:
  - `fill_req`=0 next cycle;
  - later stray `fill_valid` beats cause no writes;
  - the next access misses.
